// File: rtl/gradient_mag_seq_if.sv
// rtl/gradient_mag_seq_if.sv - start/tile/result bundle between the Sobel stage, gradient block and NMS stage
interface gradient_mag_seq_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int IN_W = 9
) ();
    localparam int OUT_W = 2 * IN_W + 1;

    logic                                     grad_en;
    logic                                     mode;
    logic [ROWS-1:0][COLS-1:0][IN_W-1:0]      sobel_x;
    logic [ROWS-1:0][COLS-1:0][IN_W-1:0]      sobel_y;
    logic [ROWS-1:0][COLS-1:0][OUT_W-1:0]     grad_out;
    logic                                     busy;
    logic                                     grad_done;

    modport master (
        output grad_en, mode, sobel_x, sobel_y,
        input  grad_out, busy, grad_done
    );

    modport slave (
        input  grad_en, mode, sobel_x, sobel_y,
        output grad_out, busy, grad_done
    );
endinterface

// File: rtl/gradient_mag_seq.sv
// rtl/gradient_mag_seq.sv - tile gradient magnitude, LANES elements per cycle, 2-stage pipeline
module gradient_mag_seq #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int IN_W   = 9,
    parameter int LANES  = 4,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst,
    gradient_mag_seq_if.slave   bus
);
    localparam int N     = ROWS * COLS;
    localparam int G     = N / LANES;
    localparam int SQ_W  = 2 * IN_W;
    localparam int OUT_W = SQ_W + 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    if ((N % LANES) != 0) begin : g_bad_lanes
        $error("gradient_mag_seq: LANES must divide ROWS*COLS");
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FLUSH} state_t;

    // Group-major views share the flat r*COLS+c bit layout of the tile ports.
    typedef logic [G-1:0][LANES-1:0][IN_W-1:0]  in_grp_t;
    typedef logic [G-1:0][LANES-1:0][OUT_W-1:0] out_grp_t;
    typedef logic [LANES-1:0][SQ_W-1:0]         lane_t;

    state_t   state_q, state_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic     busy_q, busy_d;
    logic     done_q, done_d;
    logic     capture;
    logic     s1_load;

    in_grp_t  x_q, y_q;
    logic     mode_q;
    lane_t    s1_a_q, s1_b_q;
    logic     s1_valid_q;
    logic [GW-1:0] s1_grp_q;
    out_grp_t grad_q;

    function automatic logic [SQ_W-1:0] elem_val(input logic [IN_W-1:0] v, input logic m);
        logic [IN_W:0]          ext;
        logic [IN_W:0]          mag;
        logic signed [SQ_W-1:0] sw;
        ext = (SIGNED != 0) ? {v[IN_W-1], v} : {1'b0, v};
        mag = ext[IN_W] ? (-ext) : ext;
        sw  = SQ_W'($signed(ext));
        // Largest square always fits SQ_W bits, so the truncated product is exact.
        if (m)
            return {{(SQ_W-IN_W-1){1'b0}}, mag};
        else
            return $unsigned(sw * sw);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;
        s1_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.grad_en) begin
                    capture = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                s1_load = 1'b1;
                if (cnt_q == GW'(G - 1))
                    state_d = S_FLUSH;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_grp_q   <= '0;
            grad_q     <= '0;
        end else begin
            if (capture) begin
                x_q    <= bus.sobel_x;
                y_q    <= bus.sobel_y;
                mode_q <= bus.mode;
            end
            s1_valid_q <= s1_load;
            if (s1_load) begin
                s1_grp_q <= cnt_q;
                for (int l = 0; l < LANES; l++) begin
                    s1_a_q[l] <= elem_val(x_q[cnt_q][l], mode_q);
                    s1_b_q[l] <= elem_val(y_q[cnt_q][l], mode_q);
                end
            end
            if (s1_valid_q) begin
                for (int l = 0; l < LANES; l++)
                    grad_q[s1_grp_q][l] <= {1'b0, s1_a_q[l]} + {1'b0, s1_b_q[l]};
            end
        end
    end

    assign bus.grad_out  = grad_q;
    assign bus.busy      = busy_q;
    assign bus.grad_done = done_q;
endmodule

// File: tb/tb_gradient_mag_seq.sv
// tb/tb_gradient_mag_seq.sv - directed self-checking bench for gradient_mag_seq
module tb_gradient_mag_seq;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int IN_W  = 9;
    localparam int OUT_W = 19;

    typedef logic [ROWS-1:0][COLS-1:0][OUT_W-1:0] out_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gradient_mag_seq_if #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W)) bus4 ();
    gradient_mag_seq_if #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W)) bus1 ();

    gradient_mag_seq #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .LANES(4), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    gradient_mag_seq #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .LANES(1), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic m);
        bus4.mode    = m;
        bus4.grad_en = 1'b1;
        tick();
        bus4.grad_en = 1'b0;
    endtask

    task automatic wait_done(input bit l1, input int budget, output int edges, output int bc);
        edges = 0;
        bc    = 0;
        while (!(l1 ? bus1.grad_done : bus4.grad_done) && edges < budget) begin
            if (l1 ? bus1.busy : bus4.busy) bc++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.grad_en = 1'b1;
        bus4.mode    = 1'b0;
        bus4.sobel_x = {16{9'h055}};
        bus4.sobel_y = {16{9'h0A3}};
        tick(); tick();
        checks++; if (bus4.grad_out !== '0) begin errors++; $display("FAIL reset_grad_out: got %h expected 0", bus4.grad_out); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus4.busy); end
        checks++; if (bus4.grad_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus4.grad_done); end
        bus4.grad_en = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus4.grad_out !== '0) begin errors++; $display("FAIL post_reset_grad_out: got %h expected 0", bus4.grad_out); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", bus4.busy); end
        checks++; if (bus4.grad_done !== 1'b0) begin errors++; $display("FAIL post_reset_done: got %b expected 0", bus4.grad_done); end
    endtask

    task automatic test_mode0();
        out_t exp;
        int   edges, bc;
        bus4.sobel_x = '0; bus4.sobel_y = '0;
        bus4.sobel_x[0][0] = 9'd1;   bus4.sobel_y[0][0] = 9'd1;
        bus4.sobel_x[1][1] = 9'd3;   bus4.sobel_y[1][1] = 9'd3;
        bus4.sobel_x[2][1] = 9'd255;
        bus4.sobel_x[3][3] = 9'd60;
        exp = '0;
        exp[0][0] = 19'd2; exp[1][1] = 19'd18; exp[2][1] = 19'd65025; exp[3][3] = 19'd3600;
        start4(1'b0);
        wait_done(1'b0, 20, edges, bc);
        checks++; if (edges != 5) begin errors++; $display("FAIL mode0_latency: got %0d edges expected 5", edges); end
        checks++; if (bc != 5) begin errors++; $display("FAIL mode0_busy_cycles: got %0d expected 5", bc); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL mode0_busy_at_done: got %b expected 0", bus4.busy); end
        checks++; if (bus4.grad_out !== exp) begin errors++; $display("FAIL mode0_values: got %h expected %h", bus4.grad_out, exp); end
        tick();
        checks++; if (bus4.grad_done !== 1'b0) begin errors++; $display("FAIL mode0_done_width: got %b expected 0", bus4.grad_done); end
    endtask

    task automatic test_signed();
        out_t exp;
        int   edges, bc;
        bus4.sobel_x = {16{9'h100}};
        bus4.sobel_y = {16{9'h100}};
        start4(1'b0);
        wait_done(1'b0, 20, edges, bc);
        exp = {16{19'd131072}};
        checks++; if (bus4.grad_out !== exp) begin errors++; $display("FAIL signed_min_sq: got %h expected %h", bus4.grad_out, exp); end
        bus4.sobel_x = '0; bus4.sobel_y = '0;
        bus4.sobel_x[0][1] = 9'd255;
        bus4.sobel_y[0][1] = 9'h101;
        tick();
        start4(1'b0);
        wait_done(1'b0, 20, edges, bc);
        exp = '0;
        exp[0][1] = 19'd130050;
        checks++; if (edges != 5) begin errors++; $display("FAIL signed_latency: got %0d edges expected 5", edges); end
        checks++; if (bus4.grad_out !== exp) begin errors++; $display("FAIL signed_pm255: got %h expected %h", bus4.grad_out, exp); end
    endtask

    task automatic test_mode1();
        out_t exp;
        int   edges, bc;
        bus4.sobel_x = '0; bus4.sobel_y = '0;
        bus4.sobel_x[0][0] = 9'h1FD; bus4.sobel_y[0][0] = 9'd4;
        bus4.sobel_x[1][2] = 9'h100; bus4.sobel_y[1][2] = 9'd255;
        tick();
        start4(1'b1);
        tick();
        bus4.mode = 1'b0;
        wait_done(1'b0, 20, edges, bc);
        exp = '0;
        exp[0][0] = 19'd7; exp[1][2] = 19'd511;
        checks++; if (edges + 1 != 5) begin errors++; $display("FAIL mode1_latency: got %0d edges expected 5", edges + 1); end
        checks++; if (bus4.grad_out !== exp) begin errors++; $display("FAIL mode1_values: got %h expected %h", bus4.grad_out, exp); end
        tick();
        start4(1'b0);
        tick();
        bus4.mode = 1'b1;
        wait_done(1'b0, 20, edges, bc);
        exp = '0;
        exp[0][0] = 19'd25; exp[1][2] = 19'd130561;
        checks++; if (bus4.grad_out !== exp) begin errors++; $display("FAIL mode0_toggle_values: got %h expected %h", bus4.grad_out, exp); end
    endtask

    task automatic test_protocol();
        int edges, bc;
        tick();
        bus4.sobel_x = '0; bus4.sobel_y = '0;
        bus4.sobel_x[0][0] = 9'd2;
        bus4.sobel_y[3][3] = 9'd5;
        bus4.mode    = 1'b0;
        bus4.grad_en = 1'b1;
        tick();
        bus4.sobel_x[0][0] = 9'd7;
        bus4.sobel_y[3][3] = 9'd0;
        wait_done(1'b0, 20, edges, bc);
        checks++; if (edges != 5) begin errors++; $display("FAIL hold_en_latency: got %0d edges expected 5", edges); end
        checks++; if (bus4.grad_out[0][0] !== 19'd4) begin errors++; $display("FAIL hold_en_capture00: got %0d expected 4", bus4.grad_out[0][0]); end
        checks++; if (bus4.grad_out[3][3] !== 19'd25) begin errors++; $display("FAIL hold_en_capture33: got %0d expected 25", bus4.grad_out[3][3]); end
        tick();
        bus4.grad_en = 1'b0;
        checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", bus4.busy); end
        checks++; if (bus4.grad_done !== 1'b0) begin errors++; $display("FAIL single_done: got %b expected 0", bus4.grad_done); end
        tick(); tick();
        checks++; if (bus4.grad_out[0][0] !== 19'd49) begin errors++; $display("FAIL midrun_group0_new: got %0d expected 49", bus4.grad_out[0][0]); end
        checks++; if (bus4.grad_out[3][3] !== 19'd25) begin errors++; $display("FAIL midrun_group3_old: got %0d expected 25", bus4.grad_out[3][3]); end
        wait_done(1'b0, 20, edges, bc);
        checks++; if (edges + 2 != 5) begin errors++; $display("FAIL restart_latency: got %0d edges expected 5", edges + 2); end
        checks++; if (bus4.grad_out[3][3] !== 19'd0) begin errors++; $display("FAIL restart_group3_new: got %0d expected 0", bus4.grad_out[3][3]); end
    endtask

    task automatic test_abort();
        int edges, bc, dones;
        tick();
        bus4.sobel_x = {16{9'd1}};
        bus4.sobel_y = {16{9'd1}};
        start4(1'b0);
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus4.grad_out !== '0) begin errors++; $display("FAIL abort_grad_out: got %h expected 0", bus4.grad_out); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus4.busy); end
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus4.grad_done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
        start4(1'b0);
        wait_done(1'b0, 20, edges, bc);
        checks++; if (edges != 5) begin errors++; $display("FAIL abort_rerun_latency: got %0d edges expected 5", edges); end
        checks++; if (bus4.grad_out !== {16{19'd2}}) begin errors++; $display("FAIL abort_rerun_values: got %h expected all 2", bus4.grad_out); end
    endtask

    task automatic test_lanes1();
        out_t exp;
        int   edges, bc;
        bus1.sobel_x = '0; bus1.sobel_y = '0;
        bus1.sobel_x[0][0] = 9'd1;   bus1.sobel_y[0][0] = 9'd1;
        bus1.sobel_x[1][1] = 9'd3;   bus1.sobel_y[1][1] = 9'd3;
        bus1.sobel_x[2][1] = 9'd255;
        bus1.sobel_x[3][3] = 9'd60;
        exp = '0;
        exp[0][0] = 19'd2; exp[1][1] = 19'd18; exp[2][1] = 19'd65025; exp[3][3] = 19'd3600;
        bus1.mode    = 1'b0;
        bus1.grad_en = 1'b1;
        tick();
        bus1.grad_en = 1'b0;
        wait_done(1'b1, 40, edges, bc);
        checks++; if (edges != 17) begin errors++; $display("FAIL lanes1_latency: got %0d edges expected 17", edges); end
        checks++; if (bc != 17) begin errors++; $display("FAIL lanes1_busy_cycles: got %0d expected 17", bc); end
        checks++; if (bus1.grad_out !== exp) begin errors++; $display("FAIL lanes1_values: got %h expected %h", bus1.grad_out, exp); end
    endtask

    initial begin
        rst = 1'b1;
        bus4.grad_en = 1'b0; bus4.mode = 1'b0; bus4.sobel_x = '0; bus4.sobel_y = '0;
        bus1.grad_en = 1'b0; bus1.mode = 1'b0; bus1.sobel_x = '0; bus1.sobel_y = '0;
        test_reset();
        test_mode0();
        test_signed();
        test_mode1();
        test_protocol();
        test_abort();
        test_lanes1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gradient_mag_seq.md
Name: gradient_mag_seq

Overview:
- Parametrised, sequential successor to the combinational 4x4 gradient-magnitude stage.
- Captures a ROWS x COLS tile of Sobel X/Y responses on a start request.
- Computes each element's gradient magnitude LANES elements per cycle through a 2-stage pipeline: squared L2 (x^2+y^2) or L1 (|x|+|y|), selected per run.
- Sits between the Sobel filter and the non-max-suppression/threshold stage; signals completion with a one-cycle grad_done pulse.

Parameters:
ROWS, 4, tile rows
COLS, 4, tile columns
IN_W, 9, Sobel sample width
LANES, 4, elements processed per cycle; must divide ROWS*COLS (elaboration error otherwise)
SIGNED, 1, 1 = inputs are two's complement, 0 = unsigned
(derived) N = ROWS*COLS, G = N/LANES, OUT_W = 2*IN_W+1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
grad_en  in  1  start request, sampled only in IDLE
mode  in  1  0 = x^2+y^2, 1 = |x|+|y|; sampled with grad_en
sobel_x  in  [ROWS-1:0][COLS-1:0][IN_W-1:0]  X responses
sobel_y  in  [ROWS-1:0][COLS-1:0][IN_W-1:0]  Y responses
grad_out  out  [ROWS-1:0][COLS-1:0][OUT_W-1:0]  magnitudes, registered
busy  out  1  high from capture until the final write
grad_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time):
  - grad_out all 0, busy 0, grad_done 0.
  - FSM returns to IDLE, group counter 0, pipeline valid bits cleared.
  - Mid-run reset aborts the run with no grad_done.
- FSM states IDLE, CALC, FLUSH:
  - IDLE: at edge E0 with grad_en=1, capture sobel_x, sobel_y and mode into internal registers; set busy=1; go to CALC, counter g=0.
  - CALC: each edge E(g+1), g = 0..G-1, registers stage-1 results (squares or absolute values) for group g. Group g covers flat indices i = g*LANES .. g*LANES+LANES-1, where i = r*COLS + c. After g = G-1, go to FLUSH.
  - FLUSH: stage 2 writes the last group. At that edge, grad_done goes high for exactly one cycle and busy goes low. Return to IDLE.
- Stage 2 of group g writes grad_out elements of group g at edge E(g+2). Other elements hold their values. Elements not yet rewritten keep the previous run's results.
- Latency: grad_done is high in the cycle after edge E(G+1), i.e. G+1 edges after capture (5 for the defaults).
- grad_en while busy is ignored. Input changes after E0 do not affect the run. A new start is accepted in the cycle grad_done is high (FSM already in IDLE), giving back-to-back runs.
- Arithmetic:
  - SIGNED=1: inputs sign-extended; square = x*x (non-negative); |x| computed at IN_W+1 bits, so |-256| = 256.
  - SIGNED=0: inputs zero-extended.
  - Sum is zero-extended to OUT_W, so it can never overflow: max 2*(2^IN_W-1)^2 < 2^OUT_W.
  - Mode 1 result is zero-extended to OUT_W.
- Mode is per-run (captured value); changing the mode pin mid-run has no effect.

Test Plan:
1. Reset: hold rst=1 with non-zero inputs and grad_en=1 -> grad_out all 0, busy=0, grad_done=0; after release with grad_en=0, outputs stay 0.
2. Mode 0, defaults, SIGNED=1:
   - Stimulus: [0][0] x=1,y=1; [1][1] x=3,y=3; [2][1] x=255,y=0; [3][3] x=60,y=0; rest 0; grad_en pulse.
   - Required: grad_out [0][0]=2, [1][1]=18, [2][1]=65025, [3][3]=3600, rest 0; grad_done high exactly 5 edges after capture, width 1; busy high for those 5 cycles.
3. Signed extremes, mode 0:
   - All x=y=9'h100 (-256) -> every element 131072.
   - Then x=255, y=-255 at [0][1] -> 130050.
4. Mode 1:
   - x=-3, y=4 -> 7; x=-256, y=255 -> 511; x=0, y=0 -> 0.
   - Mode pin toggled mid-run -> results unchanged.
5. Protocol:
   - Keep grad_en=1 and change sobel_x during busy -> results reflect the E0 capture only, single grad_done.
   - Immediate restart in the grad_done cycle -> second done 5 edges later.
   - Mid-run, group 0 already written by the new run while group 3 still holds the prior run's values.
6. Abort and variants:
   - Assert rst at E2 -> grad_out 0, no grad_done; a fresh run afterwards completes normally.
   - LANES=1 build -> grad_done 17 edges after capture, same values as scenario 2.
